// File: rtl/acquisition_sequencer.sv
// Acquisition sequencer: arms a DAC/ADC capture, optionally waits for an
// external trigger, holds the DAC running for adc_delay cycles before
// releasing the RAM writer, then runs for run_length cycles (0 = forever).
// A host watchdog aborts the capture into FAULT if it goes silent.
//
// Ports:
//   clk, peripheral_reset    - clock, synchronous active-high reset
//   arm, abort               - one-cycle start/stop requests
//   trigger_mode             - 0 start on arm, 1 start on trigger rising edge
//   watchdog_en              - enables watchdog supervision in DELAY/RUN
//   trigger_in, watchdog_in  - asynchronous inputs, 2-FF synchronised here
//   adc_delay                - DAC-to-RAM-writer release delay in cycles
//   run_length               - RUN duration in cycles, 0 = unlimited
//   dac_aresetn, ram_aresetn - registered active-low downstream resets
//   busy, fault, state       - status; fault is sticky until next arm
//   run_count                - cycles elapsed in RUN
module acquisition_sequencer #(
  parameter int unsigned WDOG_TIMEOUT_CYCLES = 12500000,
  parameter int unsigned RUN_W               = 32
) (
  input  logic             clk,
  input  logic             peripheral_reset,
  input  logic             arm,
  input  logic             abort,
  input  logic             trigger_mode,
  input  logic             watchdog_en,
  input  logic             trigger_in,
  input  logic             watchdog_in,
  input  logic [15:0]      adc_delay,
  input  logic [RUN_W-1:0] run_length,
  output logic             dac_aresetn,
  output logic             ram_aresetn,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [RUN_W-1:0] run_count
);

  localparam int unsigned     WD_W   = $clog2(WDOG_TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TRIG = 3'd1,
    S_DELAY     = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       dly_q, dly_d;
  logic [RUN_W-1:0]  cnt_d;
  logic              fault_d;
  logic              arm_ok;
  logic [WD_W-1:0]   wd_cnt;
  // [0] first sync stage, [1] second stage, [2] previous [1] for edge detect
  logic [2:0]        trig_sync, wd_sync;
  logic              trig_evt, wd_evt, wd_timeout;
  logic [2:0]        state_raw;

  assign trig_evt   = trig_sync[1] & ~trig_sync[2];
  assign wd_evt     = wd_sync[1] ^ wd_sync[2];
  assign wd_timeout = watchdog_en && (wd_cnt == WD_MAX) &&
                      ((state_q == S_DELAY) || (state_q == S_RUN));

  assign busy      = (state_q == S_WAIT_TRIG) || (state_q == S_DELAY) ||
                     (state_q == S_RUN);
  // Codes 6-7 cannot be reached; report them as IDLE should they appear.
  assign state_raw = state_q;
  assign state     = (state_raw > 3'd5) ? 3'd0 : state_raw;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    cnt_d   = run_count;
    fault_d = fault;
    arm_ok  = 1'b0;
    // Priority: abort > watchdog timeout > trigger/run completion > arm.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else if (wd_timeout) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        S_WAIT_TRIG: begin
          if (trig_evt) begin
            dly_d   = adc_delay;
            state_d = (adc_delay == 16'd0) ? S_RUN : S_DELAY;
          end
        end
        S_DELAY: begin
          // dly_q was loaded non-zero on entry; the last DELAY cycle sees 1.
          if (dly_q <= 16'd1) state_d = S_RUN;
          else                dly_d   = dly_q - 16'd1;
        end
        S_RUN: begin
          if ((run_length != '0) && (run_count == run_length - RUN_W'(1)))
            state_d = S_DONE;
          else if (run_count != '1)
            cnt_d = run_count + RUN_W'(1);
        end
        default: begin
          // IDLE, DONE, FAULT, and unreachable codes (which fall to IDLE).
          if ((state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAULT))
            state_d = S_IDLE;
          // An abort in IDLE does nothing but still outranks arm.
          if (arm && !abort) begin
            arm_ok  = 1'b1;
            fault_d = 1'b0;
            cnt_d   = '0;
            dly_d   = adc_delay;
            if (trigger_mode)             state_d = S_WAIT_TRIG;
            else if (adc_delay == 16'd0)  state_d = S_RUN;
            else                          state_d = S_DELAY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (peripheral_reset) begin
      state_q     <= S_IDLE;
      dly_q       <= '0;
      run_count   <= '0;
      fault       <= 1'b0;
      wd_cnt      <= '0;
      trig_sync   <= '0;
      wd_sync     <= '0;
      dac_aresetn <= 1'b0;
      ram_aresetn <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      run_count   <= cnt_d;
      fault       <= fault_d;
      trig_sync   <= {trig_sync[1:0], trigger_in};
      wd_sync     <= {wd_sync[1:0], watchdog_in};
      if (arm_ok || wd_evt)    wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
      // Decoded from next state so the resets move with the state register.
      dac_aresetn <= (state_d == S_DELAY) || (state_d == S_RUN);
      ram_aresetn <= (state_d == S_RUN);
    end
  end

endmodule

// File: tb/tb_acquisition_sequencer.sv
module tb_acquisition_sequencer;
  localparam int RW = 16;
  localparam int WD = 100;
  localparam logic [2:0] IDL = 3'd0, WTR = 3'd1, DLY = 3'd2, RUN = 3'd3,
                         DON = 3'd4, FLT = 3'd5;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic          peripheral_reset, arm, abort, trigger_mode, watchdog_en;
  logic          trigger_in, watchdog_in;
  logic [15:0]   adc_delay;
  logic [RW-1:0] run_length;
  logic          dac_aresetn, ram_aresetn, busy, fault;
  logic [2:0]    state;
  logic [RW-1:0] run_count;

  acquisition_sequencer #(.WDOG_TIMEOUT_CYCLES(WD), .RUN_W(RW)) dut (
    .clk(clk), .peripheral_reset(peripheral_reset), .arm(arm), .abort(abort),
    .trigger_mode(trigger_mode), .watchdog_en(watchdog_en),
    .trigger_in(trigger_in), .watchdog_in(watchdog_in),
    .adc_delay(adc_delay), .run_length(run_length),
    .dac_aresetn(dac_aresetn), .ram_aresetn(ram_aresetn), .busy(busy),
    .fault(fault), .state(state), .run_count(run_count)
  );

  typedef struct {
    string         tag;
    logic [2:0]    st;
    logic          dac, ram, bsy, flt;
    logic [RW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    cmp({e.tag, "_state"}, 32'(state),       32'(e.st));
    cmp({e.tag, "_dac"},   32'(dac_aresetn), 32'(e.dac));
    cmp({e.tag, "_ram"},   32'(ram_aresetn), 32'(e.ram));
    cmp({e.tag, "_busy"},  32'(busy),        32'(e.bsy));
    cmp({e.tag, "_fault"}, 32'(fault),       32'(e.flt));
    cmp({e.tag, "_cnt"},   32'(run_count),   32'(e.cnt));
  endtask

  // Queue the outputs expected after the next clock edge, clock, then check.
  task automatic step(string tag, logic [2:0] st, logic dac, logic ram,
                      logic bsy, logic flt, logic [RW-1:0] cnt);
    exp_t e;
    e.tag = tag; e.st = st; e.dac = dac; e.ram = ram;
    e.bsy = bsy; e.flt = flt; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    check_out();
  endtask

  // Arm with adc_delay=1, run_length=0 and no watchdog toggles; returns with
  // the watchdog counter at the timeout value and run_count at 99.
  task automatic run_wd(string tag);
    arm = 1'b1;
    step({tag, "_arm"}, DLY, 1, 0, 1, 0, 0);
    arm = 1'b0;
    for (int k = 1; k <= WD; k++)
      step({tag, "_run"}, RUN, 1, 1, 1, 0, RW'(k - 1));
  endtask

  initial begin
    #400000;
    $display("FAIL sim_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    peripheral_reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger_mode = 1'b0;
    watchdog_en = 1'b0; trigger_in = 1'b0; watchdog_in = 1'b0;
    adc_delay = 16'd0; run_length = '0;

    step("reset", IDL, 0, 0, 0, 0, 0);
    step("reset", IDL, 0, 0, 0, 0, 0);
    peripheral_reset = 1'b0;
    step("idle", IDL, 0, 0, 0, 0, 0);

    // Immediate start: 3 DELAY cycles then 5 RUN cycles; arm in RUN ignored.
    adc_delay = 16'd3; run_length = RW'(5); arm = 1'b1;
    step("t1_arm", DLY, 1, 0, 1, 0, 0);
    arm = 1'b0;
    step("t1_dly", DLY, 1, 0, 1, 0, 0);
    step("t1_dly", DLY, 1, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 3) arm = 1'b1;
      step("t1_run", RUN, 1, 1, 1, 0, RW'(k));
      arm = 1'b0;
    end
    step("t1_done", DON, 0, 0, 0, 0, 4);
    step("t1_done", DON, 0, 0, 0, 0, 4);

    // adc_delay=0 skips DELAY entirely.
    adc_delay = 16'd0; run_length = RW'(2); arm = 1'b1;
    step("t0_arm", RUN, 1, 1, 1, 0, 0);
    arm = 1'b0;
    step("t0_run", RUN, 1, 1, 1, 0, 1);
    step("t0_done", DON, 0, 0, 0, 0, 1);

    // Trigger edge outside WAIT_TRIG is ignored.
    trigger_mode = 1'b1; trigger_in = 1'b1;
    for (int k = 0; k < 4; k++) step("t2_trig_ign", DON, 0, 0, 0, 0, 1);
    trigger_in = 1'b0;
    for (int k = 0; k < 3; k++) step("t2_settle", DON, 0, 0, 0, 0, 1);

    // Triggered start: DELAY only on the third edge after trigger_in rises.
    adc_delay = 16'd2; run_length = RW'(3); arm = 1'b1;
    step("t2_arm", WTR, 0, 0, 1, 0, 0);
    arm = 1'b0;
    for (int k = 0; k < 9; k++) step("t2_wait", WTR, 0, 0, 1, 0, 0);
    trigger_in = 1'b1;
    step("t2_sync1", WTR, 0, 0, 1, 0, 0);
    step("t2_sync2", WTR, 0, 0, 1, 0, 0);
    step("t2_dly", DLY, 1, 0, 1, 0, 0);
    step("t2_dly", DLY, 1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("t2_run", RUN, 1, 1, 1, 0, RW'(k));
    step("t2_done", DON, 0, 0, 0, 0, 2);
    trigger_in = 1'b0;

    // Watchdog silence: FAULT once the counter has reached the timeout.
    trigger_mode = 1'b0; watchdog_en = 1'b1; adc_delay = 16'd1;
    run_length = '0;
    run_wd("t3");
    step("t3_fault", FLT, 0, 0, 0, 1, 99);
    step("t3_fault", FLT, 0, 0, 0, 1, 99);
    abort = 1'b1;
    step("t3_abort_sticky", IDL, 0, 0, 0, 1, 99);
    abort = 1'b0;

    // Toggling the watchdog every 50 cycles keeps RUN alive; arm clears fault.
    arm = 1'b1;
    step("t4_arm", DLY, 1, 0, 1, 0, 0);
    arm = 1'b0;
    for (int k = 1; k <= 240; k++) begin
      if (k % 50 == 0) watchdog_in = ~watchdog_in;
      step("t4_run", RUN, 1, 1, 1, 0, RW'(k - 1));
    end
    abort = 1'b1;
    step("t4_abort", IDL, 0, 0, 0, 0, 239);
    abort = 1'b0;

    // Abort and timeout together: abort wins, no fault.
    run_wd("t5");
    abort = 1'b1;
    step("t5_abort_wd", IDL, 0, 0, 0, 0, 99);
    // Arm with abort in IDLE: stays IDLE, run_count not cleared.
    arm = 1'b1;
    step("t5_arm_abort", IDL, 0, 0, 0, 0, 99);
    arm = 1'b0; abort = 1'b0;
    step("t5_idle", IDL, 0, 0, 0, 0, 99);

    // Reset mid-run returns every output to its reset value in one cycle.
    watchdog_en = 1'b0; arm = 1'b1;
    step("t6_arm", DLY, 1, 0, 1, 0, 0);
    arm = 1'b0;
    step("t6_run", RUN, 1, 1, 1, 0, 0);
    step("t6_run", RUN, 1, 1, 1, 0, 1);
    peripheral_reset = 1'b1;
    step("t6_reset", IDL, 0, 0, 0, 0, 0);
    peripheral_reset = 1'b0;
    step("t6_idle", IDL, 0, 0, 0, 0, 0);

    cmp("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/acquisition_sequencer.md
ACQUISITION_SEQUENCER -- requirements
Module: acquisition_sequencer

Interface
REQ-001 SHALL have parameter WDOG_TIMEOUT_CYCLES, default 12500000, meaning watchdog silence in clk cycles (100 ms at 125 MHz) before fault.
REQ-002 SHALL have parameter RUN_W, default 32, meaning width of run_length and run_count.
REQ-003 SHALL have port clk  input  1  sole clock, 125 MHz.
REQ-004 SHALL have port peripheral_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port arm  input  1  one-cycle start request from PS.
REQ-006 SHALL have port abort  input  1  one-cycle stop request from PS.
REQ-007 SHALL have port trigger_mode  input  1  0 = start on arm, 1 = start on external trigger edge.
REQ-008 SHALL have port watchdog_en  input  1  enables watchdog supervision.
REQ-009 SHALL have port trigger_in  input  1  asynchronous external trigger.
REQ-010 SHALL have port watchdog_in  input  1  asynchronous watchdog toggle from host.
REQ-011 SHALL have port adc_delay  input  16  cycles from DAC release to RAM-writer release.
REQ-012 SHALL have port run_length  input  RUN_W  RUN duration in cycles; 0 = unlimited.
REQ-013 SHALL have port dac_aresetn  output  1  active-low reset to fourier_synth/pdm.
REQ-014 SHALL have port ram_aresetn  output  1  active-low reset to write_to_ram.
REQ-015 SHALL have port busy  output  1  high in WAIT_TRIG, DELAY, RUN.
REQ-016 SHALL have port fault  output  1  sticky watchdog-timeout flag.
REQ-017 SHALL have port state  output  3  encoded current state.
REQ-018 SHALL have port run_count  output  RUN_W  cycles elapsed in RUN.

Function
REQ-019 SHALL implement states IDLE=0, WAIT_TRIG=1, DELAY=2, RUN=3, DONE=4, FAULT=5; codes 6-7 unreachable and SHALL decode as IDLE.
REQ-020 SHALL synchronise trigger_in and watchdog_in through two flip-flops each; trigger event = synchronised rising edge, watchdog event = any synchronised edge.
REQ-021 SHALL, in IDLE/DONE/FAULT on arm, go to WAIT_TRIG if trigger_mode=1, else DELAY, next cycle; clear fault, run_count and watchdog counter.
REQ-022 SHALL ignore arm while busy=1.
REQ-023 SHALL leave WAIT_TRIG for DELAY on the cycle after a trigger event; trigger edges outside WAIT_TRIG are ignored.
REQ-024 SHALL hold DELAY for exactly adc_delay cycles (adc_delay sampled on DELAY entry), then enter RUN; adc_delay=0 enters RUN directly instead of DELAY.
REQ-025 SHALL increment run_count each RUN cycle; with run_length≠0, go to DONE when run_count = run_length-1; with run_length=0, stay in RUN, run_count saturating at all-ones.
REQ-026 SHALL drive registered outputs: dac_aresetn=1 only in DELAY and RUN; ram_aresetn=1 only in RUN; both 0 elsewhere, changing in the same cycle as state.
REQ-027 SHALL keep a watchdog counter cleared by each watchdog event and on arm, saturating at WDOG_TIMEOUT_CYCLES; timeout = counter reaching WDOG_TIMEOUT_CYCLES.
REQ-028 SHALL, with watchdog_en=1 and timeout in DELAY or RUN, enter FAULT next cycle and set fault=1 until next accepted arm or reset.
REQ-029 SHALL, on abort in any state but IDLE, go to IDLE next cycle; fault is not cleared.
REQ-030 SHALL resolve simultaneous events by priority: peripheral_reset > abort > watchdog timeout > run completion/trigger > arm.
REQ-031 SHALL hold run_count value in DONE, FAULT and IDLE until the next accepted arm.

Reset
REQ-032 SHALL, while peripheral_reset=1 at a clk edge, set state=IDLE, dac_aresetn=0, ram_aresetn=0, busy=0, fault=0, run_count=0, watchdog counter=0, synchronisers=0; applies mid-run with no extra cycles.

Verification
REQ-033 SHALL cover: trigger_mode=0, adc_delay=3, run_length=5, arm -> dac_aresetn high 1 cycle later, ram_aresetn 3 cycles after that for 5 cycles, then DONE, run_count=4.
REQ-034 SHALL cover: trigger_mode=1, arm, trigger edge 10 cycles later -> DELAY entered 3 cycles after the async edge (2 sync + 1), not before.
REQ-035 SHALL cover: watchdog_en=1, WDOG_TIMEOUT_CYCLES=100, run_length=0, no watchdog toggles -> FAULT at cycle 100 after arm, both resets low, fault=1; toggling every 50 cycles -> no fault.
REQ-036 SHALL cover: abort and timeout in same cycle during RUN -> IDLE, fault=0; arm and abort together in IDLE -> stays IDLE.
REQ-037 SHALL cover: peripheral_reset asserted in RUN -> next cycle all outputs at reset values; arm during busy -> ignored, run_count unaffected.
